signed_product_accumulator: RTL
===============================

SIGNED_PRODUCT_ACCUMULATOR -- requirements
Module: signed_product_accumulator

Interface
REQ-001 Parameter ACC_W, default 40, accumulator and result width in bits; legal range 33..64.
REQ-002 Parameter CNT_W, default 16, width of the beat counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 clear  input  1  synchronous frame abort.
REQ-006 in_valid  input  1  product beat offered.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 product  input  32  signed product from the 16x16 signed multiplier.
REQ-009 in_last  input  1  qualifies the beat as the final beat of a frame.
REQ-010 out_valid  output  1  frame result held on the outputs.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 acc_out  output  ACC_W  signed frame sum.
REQ-013 beat_cnt  output  CNT_W  number of beats accepted in the frame.
REQ-014 overflow  output  1  sticky; frame sum left the ACC_W signed range at least once.

Function
REQ-015 The FSM SHALL have three states: IDLE (no beats yet), ACCUM (at least one beat accepted), and HOLD (result presented).
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM when clear=0, and 0 in HOLD or whenever clear=1.
REQ-017 A beat SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; no other edge alters the accumulator.
REQ-018 On acceptance, acc SHALL become acc + sign-extended product, computed at ACC_W+1 bits, and beat_cnt SHALL increment, wrapping modulo 2^CNT_W.
REQ-019 An accepted beat with in_last=0 SHALL move the FSM IDLE->ACCUM or ACCUM->ACCUM.
REQ-020 An accepted beat with in_last=1 SHALL move the FSM to HOLD, with out_valid=1 on the next cycle and acc_out including that beat (latency 1 cycle from the last beat).
REQ-021 A single-beat frame (in_last=1 in IDLE) SHALL be legal and SHALL go IDLE->HOLD directly.
REQ-022 In HOLD, acc_out, beat_cnt, and overflow SHALL be stable until the handshake completes.
REQ-023 An edge in HOLD with out_ready=1 SHALL clear out_valid, acc, beat_cnt, and overflow, and return the FSM to IDLE; no beat is accepted in that cycle.
REQ-024 clear=1 SHALL, on the next edge, zero acc, beat_cnt, overflow, and out_valid and force IDLE from any state, taking priority over acceptance and the output handshake.
REQ-025 Overflow SHALL be detected when the ACC_W+1-bit sum differs from its ACC_W-bit sign extension; overflow SHALL then set and remain set until the frame ends or is cleared.
REQ-026 out_valid SHALL be 0 in IDLE and ACCUM, and acc_out SHALL show the running sum in every state.

Reset
REQ-027 While rst_n=0, state SHALL be IDLE, and acc_out=0, beat_cnt=0, overflow=0, out_valid=0; in_ready SHALL be 0 during reset and 1 from the first edge after deassertion.
REQ-028 Reset mid-frame or in HOLD SHALL discard the frame with no result delivered.

Configuration
REQ-029 Macro ACC_SATURATE_EN defined: on overflow the sum SHALL clamp to +(2^(ACC_W-1))-1 or -2^(ACC_W-1) according to the sign of the true sum, and SHALL remain clamped as the new base.
REQ-030 Macro ACC_SATURATE_EN undefined: the sum SHALL wrap modulo 2^ACC_W; overflow flagging is identical in both builds.

Verification
REQ-031 Frame of products 39812471, -1000, 5 (last) -> out_valid 1 cycle after the last beat; acc_out=39811476, beat_cnt=3, overflow=0.
REQ-032 Single beat -2147483648 with in_last=1 from IDLE -> HOLD; acc_out=-2147483648, beat_cnt=1.
REQ-033 ACC_W=33, three beats of -2147483648 -> overflow=1; acc_out=-4294967296 with ACC_SATURATE_EN, and 2147483648 without it.
REQ-034 Result held with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 and outputs stable; out_ready=1 -> IDLE next cycle with all outputs zero.
REQ-035 clear=1 asserted together with an in_valid, in_last=1 beat mid-frame -> beat dropped, out_valid never asserts, acc_out=0 next cycle.
REQ-036 rst_n pulsed low asynchronously in ACCUM -> outputs zero immediately, IDLE after release, and the next frame sums from 0.

Source files
------------

// File: rtl/signed_product_accumulator.sv
// Frame accumulator for signed 32-bit multiplier products. Results are held until handed off.
// Optional build macro ACC_SATURATE_EN clamps the sum on overflow instead of wrapping.
module signed_product_accumulator #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      product,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             overflow,
  output logic [1:0]       o_dbg_state
);

  // Handshakes: a beat transfers on a rising edge where in_valid && in_ready.
  // A result transfers on a rising edge where out_valid && out_ready.
  // Neither ready depends on the matching valid.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic             r_rdy_en;
  logic             w_accept;
  logic [ACC_W:0]   w_prod_ext;
  logic [ACC_W:0]   w_sum;
  logic             w_sum_ovf;
  logic [ACC_W-1:0] w_sum_sel;

  // One extra bit of headroom so the true sum is always representable.
  assign w_prod_ext = {{(ACC_W-31){product[31]}}, product};
  assign w_sum      = {r_acc[ACC_W-1], r_acc} + w_prod_ext;
  assign w_sum_ovf  = w_sum[ACC_W] ^ w_sum[ACC_W-1];

`ifdef ACC_SATURATE_EN
  assign w_sum_sel = w_sum_ovf ? (w_sum[ACC_W] ? ACC_MIN : ACC_MAX) : w_sum[ACC_W-1:0];
`else
  assign w_sum_sel = w_sum[ACC_W-1:0];
`endif

  // r_rdy_en keeps in_ready low during reset and until the first edge after release.
  assign in_ready    = r_rdy_en && !clear && (r_state != HOLD);
  assign w_accept    = in_valid && in_ready;
  assign out_valid   = (r_state == HOLD);
  assign acc_out     = r_acc;
  assign beat_cnt    = r_cnt;
  assign overflow    = r_ovf;
  assign o_dbg_state = r_state;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    if (clear) begin
      w_state_nxt = IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_ovf_nxt   = 1'b0;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          if (w_accept) begin
            w_acc_nxt   = w_sum_sel;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            w_ovf_nxt   = r_ovf | w_sum_ovf;
            w_state_nxt = in_last ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) begin
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_rdy_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ovf    <= w_ovf_nxt;
      r_rdy_en <= 1'b1;
    end
  end

endmodule
